ps2_scancode_receiver: RTL
==========================

// Module: ps2_scancode_receiver
// PURPOSE
//  Parametrised PS/2 device-to-host receiver. Oversamples PS2_CLK/PS2_DATA, deglitches, frames 11-bit
//  packets, checks start/parity/stop, folds E0/F0 prefixes into flags and queues decoded scancodes in a
//  FWFT FIFO with valid/ready output. Sits between the PS/2 pins and game/control logic; replaces the
//  fixed arrow-key controller with a generic, error-reporting, back-pressured scancode source.
// PARAMETERS
//  CLK_DIV        250   CLK cycles per sample tick (>=2)
//  FILTER_LEN     4     consecutive equal ticks before filtered PS2_CLK changes (>=1)
//  TIMEOUT_TICKS  4000  ticks without a falling edge in RECV before frame abort
//  FIFO_DEPTH     8     scancode entries (power of 2, >=2)
// PORTS
//  CLK         in   1                   system clock
//  RST         in   1                   synchronous, active-high reset
//  PS2_CLK     in   1                   raw PS/2 clock pin (async)
//  PS2_DATA    in   1                   raw PS/2 data pin (async)
//  code_out    out  8                   scancode at FIFO head
//  code_ext    out  1                   head code was preceded by E0
//  code_break  out  1                   head code was preceded by F0 (key release)
//  code_valid  out  1                   FIFO not empty
//  code_ready  in   1                   consumer accepts head this cycle
//  frame_err   out  1                   1-cycle pulse: bad start/parity/stop or timeout
//  overflow    out  1                   1-cycle pulse: decoded code dropped, FIFO full
//  fifo_count  out  $clog2(FIFO_DEPTH)+1 entries held
// BEHAVIOUR
//  Reset: all outputs 0; tick counter 0; sync/filter state 1 (bus idle); FSM IDLE; prefix flags 0;
//   FIFO empty. RST mid-frame discards the partial frame, no frame_err.
//  Sync: PS2_CLK/PS2_DATA pass 2-FF synchronisers every CLK cycle.
//  Tick: counter 0..CLK_DIV-1; tick=1 for one cycle when counter==CLK_DIV-1, then wraps to 0.
//  Filter (on tick): filtered clk takes new value only after FILTER_LEN consecutive ticks equal to it.
//   Falling edge of filtered clk = one bit event; data sampled from synced PS2_DATA at that tick.
//  FSM: IDLE -bit event with data 0-> RECV (bit_cnt=1, idle_cnt=0); bit event with data 1 in IDLE ignored.
//   RECV: bit events shift LSB-first into 10-bit reg, bit_cnt++, idle_cnt=0; other ticks idle_cnt++.
//     bit_cnt reaches 11 -> CHECK. idle_cnt==TIMEOUT_TICKS -> frame_err pulse, prefix flags cleared, IDLE.
//   CHECK (1 cycle): valid iff odd parity over data+parity and stop==1. Invalid -> frame_err, flags
//     cleared, IDLE. Valid: E0 -> ext=1; F0 -> brk=1; any other byte -> push {ext,brk,byte}, flags
//     cleared. Return to IDLE. E1 and all other bytes are pushed unmodified.
//  Latency: code_valid rises 2 CLK cycles after the tick holding the 11th bit event (empty FIFO).
//  FIFO: FWFT; code_out/code_ext/code_break show head while code_valid. Pop when code_valid&code_ready.
//   Push when full and no pop -> entry dropped, overflow pulse, FIFO unchanged.
//   Push+pop same cycle when full -> both happen, fifo_count unchanged, no overflow.
//   Pointers wrap modulo FIFO_DEPTH; code_ready while empty is ignored.
//  frame_err and overflow never coincide (push only from valid CHECK).
// TESTING (CLK_DIV=4, FILTER_LEN=2, TIMEOUT_TICKS=50, FIFO_DEPTH=4)
//  1 Frame 0x1C, good parity, ready=1 -> one beat code_out=1C ext=0 brk=0, frame_err stays 0.
//  2 Frames E0,F0,75 -> exactly one beat code_out=75 ext=1 brk=1; next frame 72 -> ext=0 brk=0.
//  3 Frame 0x29 with parity bit flipped -> frame_err 1 pulse, code_valid stays 0; then F0 then 1C
//     -> brk=1 on 1C. Also stop bit=0 -> frame_err.
//  4 Send 5 stop after 6 bits, hold PS2_CLK high -> frame_err after 50 ticks idle; next good 0x1C
//     received normally.
//  5 ready=0, send 5 codes -> fifo_count=4, overflow pulse on 5th, head still first code; drain in order.
//  6 1-tick low glitch on PS2_CLK -> no bit event; RST asserted mid-frame -> outputs 0, FIFO empty.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host scancode receiver.
// Oversampled, deglitched framing with E0/F0 folding and FWFT queue.
module ps2_scancode_receiver #(
  parameter int CLK_DIV       = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        PS2_CLK,
  input  logic                        PS2_DATA,
  output logic [7:0]                  code_out,
  output logic                        code_ext,
  output logic                        code_break,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic          ck_s1_q, ck_s2_q;
  logic          dt_s1_q, dt_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall_w;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] idle_q;
  logic [9:0]    shift_q;
  logic          timeout_w;
  logic          frame_ok;
  logic          ferr_d, push_req;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          ovf_w;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          full, pop, do_push;
  logic [9:0]    head;

  // Two-flop synchronisers, idle-high after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      dt_s1_q <= 1'b1;
      dt_s2_q <= 1'b1;
    end else begin
      ck_s1_q <= PS2_CLK;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= PS2_DATA;
      dt_s2_q <= dt_s1_q;
    end
  end

  assign tick  = (div_q == DW'(CLK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  // Sample tick divider
  always_ff @(posedge CLK) begin
    if (RST) div_q <= '0;
    else     div_q <= div_d;
  end

  // Filtered clock only flips after FILTER_LEN agreeing ticks
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else if (tick) begin
      if (ck_s2_q != filt_q) begin
        if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q    <= ck_s2_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + FW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  assign fall_w = tick && filt_q && !ck_s2_q &&
                  (flt_cnt_q == FW'(FILTER_LEN - 1));

  assign timeout_w = (state_q == RECV) && tick && !fall_w &&
                     (idle_q == IW'(TIMEOUT_TICKS - 1));

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fall_w && !dt_s2_q) state_d = RECV;
      RECV: begin
        if (fall_w && bit_cnt_q == 4'd10) state_d = CHECK;
        else if (timeout_w)               state_d = IDLE;
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit shifter, bit counter and idle tick counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_q <= '0;
      idle_q    <= '0;
      shift_q   <= '0;
    end else if (state_q == IDLE) begin
      if (fall_w && !dt_s2_q) begin
        bit_cnt_q <= 4'd1;
        idle_q    <= '0;
      end
    end else if (state_q == RECV) begin
      if (fall_w) begin
        shift_q   <= {dt_s2_q, shift_q[9:1]};
        bit_cnt_q <= bit_cnt_q + 4'd1;
        idle_q    <= '0;
      end else if (tick) begin
        idle_q <= idle_q + IW'(1);
      end
    end
  end

  assign frame_ok = (^shift_q[8:0]) && shift_q[9];

  // FSM outputs: error, push request and prefix flag updates
  always_comb begin
    ferr_d   = 1'b0;
    push_req = 1'b0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (timeout_w) begin
      ferr_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end else if (state_q == CHECK) begin
      if (!frame_ok) begin
        ferr_d = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (shift_q[7:0] == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q[7:0] == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push_req = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = (cnt_q != '0) && code_ready;
  assign do_push = push_req && (!full || pop);
  assign ovf_w   = push_req && full && !pop;

  // Flags and single-cycle status pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      frame_err <= ferr_d;
      overflow  <= ovf_w;
    end
  end

  // Queue storage, written at the tail
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_q] <= {ext_q, brk_q, shift_q[7:0]};
  end

  // Queue pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      if (do_push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!do_push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign head       = mem[rd_q];
  assign code_valid = (cnt_q != '0);
  assign code_out   = code_valid ? head[7:0] : 8'h00;
  assign code_ext   = code_valid && head[9];
  assign code_break = code_valid && head[8];
  assign fifo_count = cnt_q;

endmodule
